// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding carried
// through every pipeline stage.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } shifter_mode_t;

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Bundle of the shifter's request/response signals, named from the shifter's
// point of view; master drives operations in and drains results.
interface pipelined_barrel_shifter_if #(
    parameter int nb_bits_data = 32
);
    import shifter_pkg::*;

    // valid/ready: a transfer happens on a rising edge where both are 1; a
    // producer holding valid keeps its payload stable until the transfer.
    logic                            flush_i;
    logic                            valid_i;
    logic                            ready_o;
    logic [nb_bits_data-1:0]         data_i;
    logic [$clog2(nb_bits_data)-1:0] shamt_i;
    shifter_mode_t                   mode_i;
    logic                            valid_o;
    logic                            ready_i;
    logic [nb_bits_data-1:0]         data_o;

    modport master (
        output flush_i, valid_i, data_i, shamt_i, mode_i, ready_i,
        input  ready_o, valid_o, data_o
    );

    modport slave (
        input  flush_i, valid_i, data_i, shamt_i, mode_i, ready_i,
        output ready_o, valid_o, data_o
    );

endinterface

// File: rtl/shifter_stage.sv
// One pipeline stage: a fixed 2^stage_idx shift applied when its shamt bit is
// set, followed by the stage register. ROR support follows SHIFTER_ROTATE_EN.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int nb_bits_data = 32,
    parameter int stage_idx    = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            en_i,
    input  logic                            valid_i,
    input  logic [nb_bits_data-1:0]         data_i,
    input  logic [$clog2(nb_bits_data)-1:0] shamt_i,
    input  shifter_mode_t                   mode_i,
    input  logic                            sign_i,
    output logic                            valid_o,
    output logic [nb_bits_data-1:0]         data_o,
    output logic [$clog2(nb_bits_data)-1:0] shamt_o,
    output shifter_mode_t                   mode_o,
    output logic                            sign_o
);

    localparam int shift_amt = 1 << stage_idx;

    logic [nb_bits_data-1:0]         shifted;
    logic                            valid_d, valid_q;
    logic [nb_bits_data-1:0]         data_d, data_q;
    logic [$clog2(nb_bits_data)-1:0] shamt_d, shamt_q;
    shifter_mode_t                   mode_d, mode_q;
    logic                            sign_d, sign_q;

    always_comb begin
        shifted = data_i;
        if (shamt_i[stage_idx]) begin
            case (mode_i)
                MODE_SLL: shifted = data_i << shift_amt;
                MODE_SRL: shifted = data_i >> shift_amt;
                // Fill comes from the operand MSB captured at the pipeline input.
                MODE_SRA: shifted = (data_i >> shift_amt)
                                  | ({nb_bits_data{sign_i}} << (nb_bits_data - shift_amt));
`ifdef SHIFTER_ROTATE_EN
                MODE_ROR: shifted = (data_i >> shift_amt)
                                  | (data_i << (nb_bits_data - shift_amt));
`else
                MODE_ROR: shifted = data_i;
`endif
                default:  shifted = data_i;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        if (en_i) begin
            valid_d = valid_i;
            data_d  = shifted;
            shamt_d = shamt_i;
            mode_d  = mode_i;
            sign_d  = sign_i;
        end
        // Flush wins over both stall and advance; payload may go stale.
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= MODE_SLL;
            sign_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign mode_o  = mode_q;
    assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Barrel shifter built as $clog2(nb_bits_data) registered stages with a single
// global stall. Mode 2'b11 rotates right only when SHIFTER_ROTATE_EN is defined.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int nb_bits_data = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    input  logic [nb_bits_data-1:0]         data_i,
    input  logic [$clog2(nb_bits_data)-1:0] shamt_i,
    input  shifter_mode_t                   mode_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [nb_bits_data-1:0]         data_o
);

    localparam int nb_bits_shift = $clog2(nb_bits_data);

    // Index k is the input of stage k; index nb_bits_shift is the output.
    logic                     stage_valid [nb_bits_shift+1];
    logic [nb_bits_data-1:0]  stage_data  [nb_bits_shift+1];
    logic [nb_bits_shift-1:0] stage_shamt [nb_bits_shift+1];
    shifter_mode_t            stage_mode  [nb_bits_shift+1];
    logic                     stage_sign  [nb_bits_shift+1];

    logic advance;
    logic unused_tail;

    assign ready_o = ready_i || !valid_o;
    assign advance = ready_o;

    assign stage_valid[0] = valid_i;
    assign stage_data[0]  = data_i;
    assign stage_shamt[0] = shamt_i;
    assign stage_mode[0]  = mode_i;
    assign stage_sign[0]  = data_i[nb_bits_data-1];

    for (genvar k = 0; k < nb_bits_shift; k++) begin : g_stage
        shifter_stage #(
            .nb_bits_data (nb_bits_data),
            .stage_idx    (k)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .en_i    (advance),
            .valid_i (stage_valid[k]),
            .data_i  (stage_data[k]),
            .shamt_i (stage_shamt[k]),
            .mode_i  (stage_mode[k]),
            .sign_i  (stage_sign[k]),
            .valid_o (stage_valid[k+1]),
            .data_o  (stage_data[k+1]),
            .shamt_o (stage_shamt[k+1]),
            .mode_o  (stage_mode[k+1]),
            .sign_o  (stage_sign[k+1])
        );
    end

    assign valid_o = stage_valid[nb_bits_shift];
    assign data_o  = stage_data[nb_bits_shift];

    // Side-band fields are not needed past the last stage.
    assign unused_tail = ^{stage_shamt[nb_bits_shift], stage_mode[nb_bits_shift],
                           stage_sign[nb_bits_shift]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (32-bit): latency, all modes,
// back-pressure, async reset and flush. Expects ROR results when SHIFTER_ROTATE_EN is set.
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    localparam int W = 32;
    localparam int L = 5;

    logic clk;
    logic rst;
    pipelined_barrel_shifter_if #(.nb_bits_data(W)) bus ();

    int checks   = 0;
    int failures = 0;
    int sent;
    int n_out;
    int seen;
    bit sb_en = 1'b0;
    logic [W-1:0] held;
    logic [W-1:0] exp_q[$];

    pipelined_barrel_shifter #(.nb_bits_data(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (bus.flush_i),
        .valid_i (bus.valid_i),
        .ready_o (bus.ready_o),
        .data_i  (bus.data_i),
        .shamt_i (bus.shamt_i),
        .mode_i  (bus.mode_i),
        .valid_o (bus.valid_o),
        .ready_i (bus.ready_i),
        .data_o  (bus.data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input shifter_mode_t m, input logic [W-1:0] d, input logic [4:0] s);
        bus.valid_i = 1'b1;
        bus.mode_i  = m;
        bus.data_i  = d;
        bus.shamt_i = s;
    endtask

    // Issue one op with ready_i high and check it appears exactly L cycles later.
    task automatic run_one(input string tag, input shifter_mode_t m, input logic [W-1:0] d,
                           input logic [4:0] s, input logic [W-1:0] exp);
        bus.ready_i = 1'b1;
        drive(m, d, s);
        step();
        bus.valid_i = 1'b0;
        repeat (L - 2) step();
        chk({tag, "_early"}, {31'b0, bus.valid_o}, 32'd0);
        step();
        chk({tag, "_valid"}, {31'b0, bus.valid_o}, 32'd1);
        chk({tag, "_data"}, bus.data_o, exp);
        step();
    endtask

    // Scoreboard for the back-pressure stream.
    always @(negedge clk) begin
        if (sb_en && bus.valid_o) begin
            if (bus.ready_i) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL sb_order observed=extra_result expected=no_result");
                end
                if (exp_q.size() > 0) begin
                    chk("sb_data", bus.data_o, exp_q.pop_front());
                    n_out++;
                end
            end else begin
                chk("sb_stall_ready_o", {31'b0, bus.ready_o}, 32'd0);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.shamt_i = '0;
        bus.mode_i  = MODE_SLL;
        bus.ready_i = 1'b0;
        step();
        step();
        chk("reset_valid_o", {31'b0, bus.valid_o}, 32'd0);
        chk("reset_data_o", bus.data_o, 32'd0);
        chk("reset_ready_o", {31'b0, bus.ready_o}, 32'd1);

        // First op is presented in the cycle reset is released.
        rst = 1'b0;
        run_one("sra_neg_4", MODE_SRA, 32'h8000_0000, 5'd4, 32'hF800_0000);
        run_one("sra_pos_4", MODE_SRA, 32'h4000_0000, 5'd4, 32'h0400_0000);
        run_one("sra_neg_31", MODE_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        run_one("sll_1_31", MODE_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000);
        run_one("srl_f_28", MODE_SRL, 32'hF000_0000, 5'd28, 32'h0000_000F);
        run_one("srl_msb_4", MODE_SRL, 32'h8000_0000, 5'd4, 32'h0800_0000);
        run_one("sll_0", MODE_SLL, 32'hA5A5_5A5A, 5'd0, 32'hA5A5_5A5A);
        run_one("srl_0", MODE_SRL, 32'hA5A5_5A5A, 5'd0, 32'hA5A5_5A5A);
        run_one("sra_0", MODE_SRA, 32'hA5A5_5A5A, 5'd0, 32'hA5A5_5A5A);
        run_one("ror_0", MODE_ROR, 32'hA5A5_5A5A, 5'd0, 32'hA5A5_5A5A);
`ifdef SHIFTER_ROTATE_EN
        run_one("ror_1_1", MODE_ROR, 32'h0000_0001, 5'd1, 32'h8000_0000);
        run_one("ror_8", MODE_ROR, 32'h1234_5678, 5'd8, 32'h7812_3456);
`else
        run_one("ror_1_1", MODE_ROR, 32'h0000_0001, 5'd1, 32'h0000_0001);
        run_one("ror_8", MODE_ROR, 32'h1234_5678, 5'd8, 32'h1234_5678);
`endif

        // Back-pressure: 8 back-to-back SLL ops, ready_i low for cycles 6..8.
        sb_en = 1'b1;
        sent  = 0;
        n_out = 0;
        held  = '0;
        for (int t = 0; t < 60 && (sent < 8 || exp_q.size() > 0); t++) begin
            bus.ready_i = !(t >= 6 && t <= 8);
            if (sent < 8) drive(MODE_SLL, 32'(32'h100 + sent), sent[4:0]);
            else bus.valid_i = 1'b0;
            #1;
            if (t == 6) held = bus.data_o;
            if (t == 8) begin
                chk("bp_valid_o_high", {31'b0, bus.valid_o}, 32'd1);
                chk("bp_ready_o_low", {31'b0, bus.ready_o}, 32'd0);
                chk("bp_hold_data", bus.data_o, held);
            end
            if (bus.valid_i && bus.ready_o) begin
                exp_q.push_back(32'((32'h100 + sent) << sent));
                sent++;
            end
            step();
        end
        bus.valid_i = 1'b0;
        sb_en = 1'b0;
        chk("bp_sent", 32'(sent), 32'd8);
        chk("bp_received", 32'(n_out), 32'd8);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Async reset with three ops in flight, the oldest parked at the output.
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(MODE_SLL, 32'(32'h11 * (i + 1)), 5'd1);
            step();
        end
        bus.valid_i = 1'b0;
        for (int i = 0; i < 10 && !bus.valid_o; i++) step();
        chk("rst_pre_valid", {31'b0, bus.valid_o}, 32'd1);
        chk("rst_pre_data", bus.data_o, 32'h0000_0022);
        rst = 1'b1;
        #1;
        chk("rst_async_valid_o", {31'b0, bus.valid_o}, 32'd0);
        chk("rst_async_data_o", bus.data_o, 32'd0);
        chk("rst_async_ready_o", {31'b0, bus.ready_o}, 32'd1);
        step();
        step();
        rst = 1'b0;
        bus.ready_i = 1'b1;
        seen = 0;
        repeat (8) begin
            step();
            if (bus.valid_o) seen++;
        end
        chk("rst_no_stale", 32'(seen), 32'd0);

        // Flush while stalled, with a new op presented in the same cycle.
        bus.ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(MODE_SRL, 32'hFF00_0000, 5'd8);
            step();
        end
        bus.valid_i = 1'b0;
        for (int i = 0; i < 10 && !bus.valid_o; i++) step();
        chk("flush_pre_valid", {31'b0, bus.valid_o}, 32'd1);
        chk("flush_pre_data", bus.data_o, 32'h00FF_0000);
        bus.flush_i = 1'b1;
        drive(MODE_SLL, 32'h0000_1234, 5'd0);
        #1;
        chk("flush_stalled_ready_o", {31'b0, bus.ready_o}, 32'd0);
        step();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("flush_valid_cleared", {31'b0, bus.valid_o}, 32'd0);
        chk("flush_ready_o", {31'b0, bus.ready_o}, 32'd1);
        bus.ready_i = 1'b1;
        seen = 0;
        repeat (8) begin
            step();
            if (bus.valid_o) seen++;
        end
        chk("flush_not_issued", 32'(seen), 32'd0);
        run_one("post_flush_sll", MODE_SLL, 32'h0000_0003, 5'd2, 32'h0000_000C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
